// File: rtl/zaap_hd_classify_if.sv
// HD value stream between the HD transform and the classify stage.
// Master drives valid/data, slave answers with ready.
interface zaap_hd_classify_if #(
    parameter int W = 7
);
    logic         valid;
    logic [W-1:0] data;
    logic         ready;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/zaap_hd_classify.sv
// Classifies HD values into raw key bits, reliability mask and erasure count.
// Optional: ZAAP_HD_EARLY_FAIL_EN abandons the stream once erasures exceed t.
module zaap_hd_classify #(
    parameter int N  = 128,
    parameter int W  = 7,
    parameter int CW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [W-1:0]      Hsl,
    input  logic [W-1:0]      Hsh,
    input  logic [W-1:0]      t,
    zaap_hd_classify_if.slave hd,
    output logic [N-1:0]      key,
    output logic [N-1:0]      mask,
    output logic [CW-1:0]     erase_cnt,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic              cfg_err
);
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        CHECK,
        DONE
    } state_t;

    state_t        state;
    logic [W-1:0]  hsl_q;
    logic [W-1:0]  hsh_q;
    logic [W-1:0]  t_q;
    logic [IW-1:0] idx;

    logic          xfer;
    logic          is_lo;
    logic          is_hi;
    logic          is_er;
    logic          stop;
    logic [CW-1:0] ers_nxt;

    always_comb begin
        xfer    = hd.valid & hd.ready;
        is_lo   = hd.data <= hsl_q;
        is_hi   = hd.data >= hsh_q;
        is_er   = !is_lo && !is_hi;
        ers_nxt = erase_cnt + CW'(is_er);
`ifdef ZAAP_HD_EARLY_FAIL_EN
        stop    = ers_nxt > CW'(t_q);
`else
        stop    = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            hsl_q     <= '0;
            hsh_q     <= '0;
            t_q       <= '0;
            idx       <= '0;
            key       <= '0;
            mask      <= '0;
            erase_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            cfg_err   <= 1'b0;
            hd.ready  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        hsl_q     <= Hsl;
                        hsh_q     <= Hsh;
                        t_q       <= t;
                        idx       <= '0;
                        key       <= '0;
                        mask      <= '0;
                        erase_cnt <= '0;
                        busy      <= 1'b1;
                        if (Hsl >= Hsh) begin
                            cfg_err <= 1'b1;
                            fail    <= 1'b1;
                            done    <= 1'b1;
                            state   <= DONE;
                        end else begin
                            cfg_err  <= 1'b0;
                            fail     <= 1'b0;
                            hd.ready <= 1'b1;
                            state    <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (xfer) begin
                        key[idx]  <= is_hi;
                        mask[idx] <= !is_er;
                        erase_cnt <= ers_nxt;
                        idx       <= idx + 1'b1;
                        // Early stop leaves the remaining bits cleared
                        if (idx == LAST || stop) begin
                            hd.ready <= 1'b0;
                            state    <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    fail  <= erase_cnt > CW'(t_q);
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_zaap_hd_classify.sv
// Directed bench for zaap_hd_classify with a run-level scoreboard.
// Follows ZAAP_HD_EARLY_FAIL_EN in its reference model when defined.
module tb_zaap_hd_classify;
    localparam int N  = 128;
    localparam int W  = 7;
    localparam int CW = 8;

    typedef struct {
        logic [N-1:0] key;
        logic [N-1:0] mask;
        int           ecnt;
        logic         fail;
        logic         cfg;
        int           xfers;
        int           cyc;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          start;
    logic [W-1:0]  Hsl;
    logic [W-1:0]  Hsh;
    logic [W-1:0]  t;
    logic [N-1:0]  key;
    logic [N-1:0]  mask;
    logic [CW-1:0] erase_cnt;
    logic          busy;
    logic          done;
    logic          fail;
    logic          cfg_err;

    zaap_hd_classify_if #(.W(W)) hd_bus ();

    zaap_hd_classify #(.N(N), .W(W), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .Hsl       (Hsl),
        .Hsh       (Hsh),
        .t         (t),
        .hd        (hd_bus),
        .key       (key),
        .mask      (mask),
        .erase_cnt (erase_cnt),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .cfg_err   (cfg_err)
    );

    logic [W-1:0] hd_vec [N];
    exp_t         sb [$];
    int           total;
    int           passed;
    int           done_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    task automatic chk(input string tag, input logic [N-1:0] obs,
                       input logic [N-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    function automatic exp_t model(input logic [W-1:0] lo, hi, tt);
        exp_t e;
        e.key   = '0;
        e.mask  = '0;
        e.ecnt  = 0;
        e.cfg   = 1'b0;
        e.xfers = 0;
        if (lo >= hi) begin
            e.cfg  = 1'b1;
            e.fail = 1'b1;
            e.cyc  = 2;
            return e;
        end
        for (int i = 0; i < N; i++) begin
            e.xfers++;
            if (hd_vec[i] <= lo) begin
                e.mask[i] = 1'b1;
            end else if (hd_vec[i] >= hi) begin
                e.key[i]  = 1'b1;
                e.mask[i] = 1'b1;
            end else begin
                e.ecnt++;
            end
`ifdef ZAAP_HD_EARLY_FAIL_EN
            if (e.ecnt > int'(tt)) break;
`endif
        end
        e.fail = e.ecnt > int'(tt);
        e.cyc  = e.xfers + 3;
        return e;
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_key"}, key, '0);
        chk({tag, "_mask"}, mask, '0);
        chk({tag, "_ecnt"}, N'(erase_cnt), '0);
        chk({tag, "_flags"},
            N'({busy, done, fail, cfg_err, hd_bus.ready}), '0);
    endtask

    task automatic run(input string tag, input logic [W-1:0] lo, hi, tt,
                       input bit stall, input bit v_at_start,
                       input int busy_start_at, input int abort_at,
                       input bit start_on_done);
        exp_t e;
        exp_t got_e;
        int   cyc;
        int   idx;
        int   last_x;
        int   d0;
        bit   got;
        bit   rdy_seen;
        e = model(lo, hi, tt);
        sb.push_back(e);
        d0       = done_cnt;
        idx      = 0;
        last_x   = 0;
        got      = 1'b0;
        rdy_seen = 1'b0;
        @(negedge clk);
        start        = 1'b1;
        Hsl          = lo;
        Hsh          = hi;
        t            = tt;
        hd_bus.valid = v_at_start;
        hd_bus.data  = hd_vec[0];
        cyc          = 1;
        while (cyc < 1000) begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
            Hsl = W'($urandom);
            Hsh = W'($urandom);
            t   = W'($urandom);
            if (abort_at >= 0 && idx == abort_at) begin
                rst = 1'b0;
                #1;
                chk_reset({tag, "_abort"});
                @(negedge clk);
                rst          = 1'b1;
                hd_bus.valid = 1'b0;
                void'(sb.pop_back());
                chk({tag, "_no_done"}, N'(done_cnt), N'(d0));
                return;
            end
            if (done) begin
                got = 1'b1;
                if (start_on_done) begin
                    start = 1'b1;
                    Hsl   = 7'd1;
                    Hsh   = 7'd100;
                end
                break;
            end
            if (cyc == busy_start_at) begin
                start = 1'b1;
                Hsl   = 7'd0;
                Hsh   = 7'd127;
                t     = 7'd127;
            end
            if (hd_bus.ready) rdy_seen = 1'b1;
            hd_bus.valid = idx < N && (!stall || $urandom_range(0, 1) == 1);
            hd_bus.data  = idx < N ? hd_vec[idx] : '0;
            if (hd_bus.valid && hd_bus.ready) begin
                idx++;
                last_x = cyc;
            end
        end
        hd_bus.valid = 1'b0;
        chk({tag, "_done_seen"}, N'(got), N'(1));
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, N'(0), N'(1));
            return;
        end
        got_e = sb.pop_front();
        chk({tag, "_key"}, key, got_e.key);
        chk({tag, "_mask"}, mask, got_e.mask);
        chk({tag, "_ecnt"}, N'(erase_cnt), N'(got_e.ecnt));
        chk({tag, "_fail"}, N'(fail), N'(got_e.fail));
        chk({tag, "_cfg_err"}, N'(cfg_err), N'(got_e.cfg));
        chk({tag, "_xfers"}, N'(idx), N'(got_e.xfers));
        if (got_e.cfg) begin
            chk({tag, "_cyc"}, N'(cyc), N'(2));
            chk({tag, "_rdy_never"}, N'(rdy_seen), N'(0));
        end else begin
            chk({tag, "_last_to_done"}, N'(cyc - last_x), N'(2));
            if (!stall) chk({tag, "_cyc"}, N'(cyc), N'(got_e.cyc));
        end
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_done_pulse"}, N'({done, busy}), N'(0));
        chk({tag, "_done_cnt"}, N'(done_cnt), N'(d0 + 1));
        repeat (2) @(negedge clk);
        chk({tag, "_idle"}, N'({busy, done, hd_bus.ready}), N'(0));
        chk({tag, "_hold_key"}, key, got_e.key);
        chk({tag, "_hold_fail"}, N'({fail, cfg_err}),
            N'({got_e.fail, got_e.cfg}));
    endtask

    initial begin
        total        = 0;
        passed       = 0;
        done_cnt     = 0;
        rst          = 1'b0;
        start        = 1'b0;
        Hsl          = '0;
        Hsh          = '0;
        t            = '0;
        hd_bus.valid = 1'b0;
        hd_bus.data  = '0;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b1;

        for (int i = 0; i < N; i++) hd_vec[i] = (i % 2 == 0) ? 7'd5 : 7'd60;
        run("abort", 7'd12, 7'd51, 7'd7, 1'b0, 1'b0, -1, 40, 1'b0);
        run("nominal", 7'd12, 7'd51, 7'd7, 1'b0, 1'b0, -1, -1, 1'b0);
        chk("nom_key_const", key, {(N / 2){2'b10}});
        chk("nom_mask_const", mask, '1);

        for (int i = 0; i < N; i++) hd_vec[i] = 7'd0;
        hd_vec[0] = 7'd12;
        hd_vec[1] = 7'd51;
        for (int i = 2; i < 10; i++) hd_vec[i] = 7'd30;
        run("equal", 7'd12, 7'd51, 7'd7, 1'b0, 1'b1, -1, -1, 1'b0);
        chk("equal_fail", N'(fail), N'(1));

        for (int i = 0; i < N; i++) hd_vec[i] = (i % 2 == 0) ? 7'd5 : 7'd60;
        run("stall", 7'd12, 7'd51, 7'd7, 1'b1, 1'b1, 50, -1, 1'b0);

        run("cfg", 7'd51, 7'd12, 7'd7, 1'b0, 1'b1, -1, -1, 1'b1);

        for (int i = 0; i < N; i++) hd_vec[i] = 7'd30;
        hd_vec[77] = 7'd0;
        run("tmax", 7'd12, 7'd51, 7'd127, 1'b0, 1'b0, -1, -1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
